upsample_channel_scheduler: RTL and testbench

UPSAMPLE_CHANNEL_SCHEDULER -- requirements
Module: upsample_channel_scheduler

---
 rtl/upsample_pkg.sv | 20 ++
 rtl/addr_translate.sv | 13 +
 rtl/upsample_channel_scheduler.sv | 119 +++++++++++
 tb/tb_upsample_channel_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared types and helpers for the upsample channel scheduler.
package upsample_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [2:0] MAX_SIZE = 3'd4;

  // Words consumed per channel on the input side: (4<<size)^2.
  function automatic logic [31:0] in_stride(input logic [2:0] size);
    return 32'd1 << (32'(size) * 32'd2 + 32'd4);
  endfunction

endpackage

// File: rtl/addr_translate.sv
// Translates a core-local word address into a global one by adding a base.
module addr_translate #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned GADDR_W = 20
) (
  input  logic [GADDR_W-1:0] base,
  input  logic [ADDR_W-1:0]  offset,
  output logic [GADDR_W-1:0] addr_c
);

  assign addr_c = base + GADDR_W'(offset);

endmodule

// File: rtl/upsample_channel_scheduler.sv
// Sequences an upsample core over a run of channels, one launch per channel,
// and maps the core's local addresses onto per-channel global memory windows.
module upsample_channel_scheduler
  import upsample_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned GADDR_W = 20,
  parameter int unsigned CH_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [2:0]         cfg_size,
  input  logic [CH_W-1:0]    cfg_num_ch,
  input  logic [GADDR_W-1:0] cfg_in_base,
  input  logic [GADDR_W-1:0] cfg_out_base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CH_W-1:0]    ch_idx,
  output logic               up_start,
  output logic [2:0]         up_size,
  input  logic               up_done,
  input  logic [ADDR_W-1:0]  up_addr_input,
  input  logic [ADDR_W-1:0]  up_addr_output,
  input  logic               up_en_write_out,
  output logic [GADDR_W-1:0] mem_rd_addr,
  output logic [GADDR_W-1:0] mem_wr_addr,
  output logic               mem_wr_en
);

  state_t             state;
  logic [CH_W-1:0]    num_ch_q;
  logic [GADDR_W-1:0] in_ptr;
  logic [GADDR_W-1:0] out_ptr;

  // Bases are captured straight into the channel pointers on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      num_ch_q <= '0;
      in_ptr   <= '0;
      out_ptr  <= '0;
      ch_idx   <= '0;
      up_size  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      up_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      up_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            err      <= 1'b0;
            up_size  <= cfg_size;
            num_ch_q <= cfg_num_ch;
            in_ptr   <= cfg_in_base;
            out_ptr  <= cfg_out_base;
          end
        end
        S_LOAD: begin
          if (up_size > MAX_SIZE) begin
            err   <= 1'b1;
            state <= S_FINISH;
          end else if (num_ch_q == '0) begin
            state <= S_FINISH;
          end else begin
            ch_idx   <= '0;
            up_start <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_RUN;
        S_RUN: begin
          if (up_done) state <= S_NEXT;
        end
        S_NEXT: begin
          ch_idx  <= ch_idx + CH_W'(1);
          in_ptr  <= in_ptr + GADDR_W'(in_stride(up_size));
          out_ptr <= out_ptr + GADDR_W'({in_stride(up_size), 2'b00});
          if ((ch_idx + CH_W'(1)) == num_ch_q) begin
            state <= S_FINISH;
          end else begin
            up_start <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  addr_translate #(.ADDR_W(ADDR_W), .GADDR_W(GADDR_W)) u_rd_xlate (
    .base   (in_ptr),
    .offset (up_addr_input),
    .addr_c (mem_rd_addr)
  );

  addr_translate #(.ADDR_W(ADDR_W), .GADDR_W(GADDR_W)) u_wr_xlate (
    .base   (out_ptr),
    .offset (up_addr_output),
    .addr_c (mem_wr_addr)
  );

  assign mem_wr_en = up_en_write_out && (state == S_RUN);

endmodule

// File: tb/tb_upsample_channel_scheduler.sv
// Directed + randomized bench for the channel scheduler against a schedule model.
module tb_upsample_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [2:0]  cfg_size;
  logic [7:0]  cfg_num_ch;
  logic [19:0] cfg_in_base;
  logic [19:0] cfg_out_base;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  ch_idx;
  logic        up_start;
  logic [2:0]  up_size;
  logic        up_done;
  logic [13:0] up_addr_input;
  logic [13:0] up_addr_output;
  logic        up_en_write_out;
  logic [19:0] mem_rd_addr;
  logic [19:0] mem_wr_addr;
  logic        mem_wr_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  upsample_channel_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_size        (cfg_size),
    .cfg_num_ch      (cfg_num_ch),
    .cfg_in_base     (cfg_in_base),
    .cfg_out_base    (cfg_out_base),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .ch_idx          (ch_idx),
    .up_start        (up_start),
    .up_size         (up_size),
    .up_done         (up_done),
    .up_addr_input   (up_addr_input),
    .up_addr_output  (up_addr_output),
    .up_en_write_out (up_en_write_out),
    .mem_rd_addr     (mem_rd_addr),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_en       (mem_wr_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One job from a cycle just after a rising edge. Channel i launches at cycle lt[i],
  // runs dly[i] cycles, and the core reports completion in the last of them.
  task automatic run_job(input logic [2:0] size, input int nch, input logic [19:0] ib,
                         input logic [19:0] ob, input int dmin, input int dmax,
                         input bit poke, input int rst_ch);
    int dly[8];
    int lt[8];
    int done_t, rst_t, starts, dones, ci;
    bit valid, en, exp_en, exp_us, exp_err;
    logic [19:0] stride, exp_rd, exp_wr;
    logic [13:0] ai, ao;

    valid  = (size <= 3'd4) && (nch != 0);
    stride = (size <= 3'd4) ? 20'(32'd1 << (2 * int'(size) + 4)) : 20'd0;
    starts = 0;
    dones  = 0;
    rst_t  = -1;
    done_t = 3;
    for (int i = 0; i < 8; i++) begin
      dly[i] = 0;
      lt[i]  = 0;
    end
    for (int i = 0; i < nch; i++) begin
      dly[i] = int'($urandom_range(dmax, dmin));
      lt[i]  = (i == 0) ? 2 : lt[i-1] + dly[i-1] + 2;
    end
    if (valid) done_t = lt[nch-1] + dly[nch-1] + 3;
    if (valid && rst_ch >= 0) rst_t = lt[rst_ch] + 1;

    cfg_size     = size;
    cfg_num_ch   = 8'(nch);
    cfg_in_base  = ib;
    cfg_out_base = ob;

    for (int t = 0; t <= done_t + 2; t++) begin
      cfg_start = (t == 0) || (poke && valid && t == lt[0] + 1);
      if (t > 0) begin
        cfg_size     = 3'($urandom);
        cfg_num_ch   = 8'($urandom);
        cfg_in_base  = 20'($urandom);
        cfg_out_base = 20'($urandom);
      end
      up_done = 1'b0;
      ci      = -1;
      exp_us  = 1'b0;
      if (valid) begin
        for (int i = 0; i < nch; i++) begin
          if (t == lt[i] + dly[i] || (poke && t == lt[i])) up_done = 1'b1;
          if (t >= lt[i] && t <= lt[i] + dly[i] + 1) ci = i;
          if (t == lt[i]) exp_us = 1'b1;
        end
      end
      ai = 14'($urandom);
      ao = 14'($urandom);
      en = 1'($urandom);
      up_addr_input   = ai;
      up_addr_output  = ao;
      up_en_write_out = en;

      if (t == rst_t) begin
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_up_start", 32'(up_start), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ch_idx", 32'(ch_idx), 32'd0);
        chk("rst_up_size", 32'(up_size), 32'd0);
        cfg_start = 1'b0;
        up_done   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk);
          #1;
          chk("post_rst_done", 32'(done), 32'd0);
          chk("post_rst_busy", 32'(busy), 32'd0);
        end
        return;
      end

      #1;
      starts += int'(up_start);
      dones  += int'(done);
      chk("busy", 32'(busy), 32'(t >= 1 && t < done_t));
      chk("done", 32'(done), 32'(t == done_t));
      chk("up_start", 32'(up_start), 32'(exp_us));
      exp_en = en && (ci >= 0) && (t > lt[ci]) && (t <= lt[ci] + dly[ci]);
      chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_en));
      if (ci >= 0) begin
        exp_rd = ib + 20'(ci) * stride + 20'(ai);
        exp_wr = ob + 20'(ci) * stride * 20'd4 + 20'(ao);
        chk("ch_idx", 32'(ch_idx), 32'(ci));
        chk("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_rd));
        chk("mem_wr_addr", 32'(mem_wr_addr), 32'(exp_wr));
      end
      if (t >= 1) begin
        exp_err = (t >= 2) && (size > 3'd4);
        chk("up_size", 32'(up_size), 32'(size));
        chk("err", 32'(err), 32'(exp_err));
      end
      @(posedge clk);
      #1;
    end
    chk("start_count", 32'(starts), 32'(valid ? nch : 0));
    chk("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    rst             = 1'b1;
    cfg_start       = 1'b0;
    cfg_size        = 3'd0;
    cfg_num_ch      = 8'd0;
    cfg_in_base     = 20'd0;
    cfg_out_base    = 20'd0;
    up_done         = 1'b0;
    up_addr_input   = 14'd0;
    up_addr_output  = 14'd0;
    up_en_write_out = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_up_start", 32'(up_start), 32'd0);
    chk("reset_ch_idx", 32'(ch_idx), 32'd0);
    chk("reset_up_size", 32'(up_size), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_job(3'd0, 3, 20'h00100, 20'h04000, 20, 20, 1'b0, -1);
    run_job(3'd5, 2, 20'h00200, 20'h00300, 1, 3, 1'b0, -1);
    run_job(3'd0, 1, 20'h00010, 20'h00020, 2, 2, 1'b0, -1);
    run_job(3'd0, 0, 20'h00400, 20'h00500, 1, 1, 1'b0, -1);
    run_job(3'd0, 2, 20'hFFFF0, 20'h0F000, 1, 4, 1'b0, -1);
    run_job(3'd1, 3, 20'($urandom), 20'($urandom), 2, 5, 1'b1, -1);
    run_job(3'd2, 3, 20'($urandom), 20'($urandom), 2, 4, 1'b0, 1);
    run_job(3'd2, 2, 20'($urandom), 20'($urandom), 1, 3, 1'b0, -1);
    run_job(3'd7, 1, 20'h00001, 20'h00002, 1, 2, 1'b0, -1);
    run_job(3'd4, 2, 20'hFF000, 20'hFC000, 1, 3, 1'b0, -1);
    for (int j = 0; j < 6; j++) begin
      run_job(3'($urandom_range(4, 0)), int'($urandom_range(4, 1)), 20'($urandom),
              20'($urandom), 1, 6, 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
